// File: rtl/sevenseg_scan_ctrl_pkg.sv
// ============================================================================
// Module : sevenseg_scan_ctrl_pkg
// Brief  : Shared types and constants for the 7-segment scan controller
//          slice. It defines the FSM state encoding, the nibble width and a
//          helper that sizes the dwell counter.
// Config : the slice honours the SEVENSEG_LZB_EN macro. See sevenseg_scan_ctrl.sv.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sevenseg_scan_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Width that holds every terminal value (max-1) of two dwell lengths.
  // The result is never less than 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sevenseg_scan_ctrl_if.sv
// ============================================================================
// Module : sevenseg_scan_ctrl_if
// Brief  : Groups the host load handshake and the display drive signals.
//          The master modport is the host side: it drives load, value_in and
//          digit_en. The slave modport is the scan controller.
// Ports  : load, value_in[4N], digit_en[N]          (master -> slave)
//          load_ack, frame_done, nibble[4], seg_en, an[N]  (slave -> master)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sevenseg_scan_ctrl_if
  import sevenseg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) ();

  logic                           load;
  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]          digit_en;
  logic                           load_ack;
  logic                           frame_done;
  logic [NIBBLE_W-1:0]            nibble;
  logic                           seg_en;
  logic [NUM_DIGITS-1:0]          an;

  modport master (
    output load, value_in, digit_en,
    input  load_ack, frame_done, nibble, seg_en, an
  );

  modport slave (
    input  load, value_in, digit_en,
    output load_ack, frame_done, nibble, seg_en, an
  );

endinterface

`default_nettype wire

// File: rtl/sevenseg_scan_ctrl_scan_timer.sv
// ============================================================================
// Module : sevenseg_scan_ctrl_scan_timer
// Brief  : Dwell counter shared by the BLANK and SHOW phases. The counter
//          restarts from 0 each time it reaches term_val. tick is high for
//          the last cycle of each dwell, so one dwell lasts term_val+1 cycles.
// Ports  : clk, rst (async, active-high)
//          term_val[CNT_W] in  : terminal count of the current phase
//          tick            out : high during the last cycle of the dwell
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sevenseg_scan_ctrl_scan_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] term_val,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == term_val);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
// ============================================================================
// Module : sevenseg_scan_ctrl
// Brief  : Time-multiplexed scan controller for a common-anode 7-segment
//          display with NUM_DIGITS digits.
//          - The controller lights one digit at a time for CLK_DIV cycles.
//          - Between digits it blanks all anodes for BLANK_CYCLES cycles.
//          - Host loads are held in a pending buffer. They are committed to the
//            shadow buffer only at a frame boundary, so the display never tears.
// Ports  : clk           system clock, rising edge
//          rst           asynchronous reset, active-high
//          bus (slave)   load/value_in/digit_en in; load_ack/frame_done/
//                        nibble/seg_en/an out (an is active-low)
// Config : SEVENSEG_LZB_EN defined enables leading-zero blanking.
//          Zero nibbles above the most significant nonzero digit are dark.
//          Digit 0 is always shown if its enable bit is set.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sevenseg_scan_ctrl
  import sevenseg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  sevenseg_scan_ctrl_if.slave       bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = cnt_width(CLK_DIV, BLANK_CYCLES);
  localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      SHOW_TERM  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_TERM = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = '1;
  localparam bit                    HAS_BLANK  = (BLANK_CYCLES > 0);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [VAL_W-1:0]        shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   shen_q, shen_d;
  logic [VAL_W-1:0]        pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    seg_en_q, seg_en_d;
  logic [NIBBLE_W-1:0]     nibble_q, nibble_d;
  logic                    load_ack_q, load_ack_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic [CNT_W-1:0]        term_val;
  logic                    boundary;
  logic [NUM_DIGITS-1:0]   vis;

  assign term_val = (state_q == ST_SHOW) ? SHOW_TERM : BLANK_TERM;

  sevenseg_scan_ctrl_scan_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .term_val (term_val),
    .tick     (tick)
  );

  // The frame boundary is the cycle in which the last digit leaves SHOW.
  assign boundary = (state_q == ST_SHOW) && tick && (idx_q == IDX_LAST);

  // Next-state, frame buffer and load handshake.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    shen_d       = shen_q;
    pend_val_d   = pend_val_q;
    pend_en_d    = pend_en_q;
    pending_d    = pending_q;
    load_ack_d   = 1'b0;
    frame_done_d = boundary;

    if (tick) begin
      if (state_q == ST_BLANK) begin
        state_d = ST_SHOW;
      end else begin
        state_d = HAS_BLANK ? ST_BLANK : ST_SHOW;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end

    if (boundary) begin
      // A load in the boundary cycle bypasses the pending buffer.
      // It also overrides any older pending value.
      if (bus.load) begin
        shadow_d   = bus.value_in;
        shen_d     = bus.digit_en;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end else if (pending_q) begin
        shadow_d   = pend_val_q;
        shen_d     = pend_en_q;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end
    end else if (bus.load) begin
      pend_val_d = bus.value_in;
      pend_en_d  = bus.digit_en;
      pending_d  = 1'b1;
    end
  end

  // Per-digit visibility. This is evaluated on the next shadow contents so
  // that a commit takes effect with the first digit of the new frame.
`ifdef SEVENSEG_LZB_EN
  always_comb begin : lzb_scan
    logic seen_nz;
    seen_nz = 1'b0;
    vis     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen_nz = seen_nz | (shadow_d[NIBBLE_W*i +: NIBBLE_W] != '0);
      vis[i]  = shen_d[i] & (seen_nz | (i == 0));
    end
  end
`else
  assign vis = shen_d;
`endif

  // Outputs are registered from the next state, so they change on the
  // same edge where the FSM transitions.
  always_comb begin
    an_d     = ANODE_OFF;
    seg_en_d = 1'b0;
    nibble_d = nibble_q;
    if (state_d == ST_SHOW) begin
      nibble_d    = shadow_d[NIBBLE_W*idx_d +: NIBBLE_W];
      seg_en_d    = vis[idx_d];
      an_d[idx_d] = ~vis[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      shadow_q     <= '0;
      shen_q       <= '0;
      pend_val_q   <= '0;
      pend_en_q    <= '0;
      pending_q    <= 1'b0;
      an_q         <= ANODE_OFF;
      seg_en_q     <= 1'b0;
      nibble_q     <= '0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shen_q       <= shen_d;
      pend_val_q   <= pend_val_d;
      pend_en_q    <= pend_en_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_en_q     <= seg_en_d;
      nibble_q     <= nibble_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg_en     = seg_en_q;
  assign bus.nibble     = nibble_q;
  assign bus.load_ack   = load_ack_q;
  assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire
